word_to_byte_fifo: RTL and testbench
====================================

WORD_TO_BYTE_FIFO -- requirements
Module: word_to_byte_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning word-entry capacity (power of two, 4..1024).
REQ-002 SHALL have parameter AF, default DEPTH-2, meaning almost-full threshold in words (used only with the macro).
REQ-003 SHALL have parameter AE, default 2, meaning almost-empty threshold in bytes (used only with the macro).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 di  input  16  write word.
REQ-007 we  input  1  write enable.
REQ-008 re  input  1  read enable, one byte per accepted read.
REQ-009 do  output  8  read byte.
REQ-010 empty_flag  output  1  no unread bytes stored.
REQ-011 full_flag  output  1  DEPTH words occupied.

Function
REQ-012 Write SHALL be accepted on a rising clk edge when we=1 and full_flag=0; di is stored at the write pointer, which then advances.
REQ-013 Write with full_flag=1 SHALL be ignored, with no pointer or flag change, even if a read is accepted in the same cycle.
REQ-014 Read SHALL be accepted when re=1 and empty_flag=0; re with empty_flag=1 SHALL be ignored and SHALL leave do unchanged.
REQ-015 Byte order: the first read of a word SHALL return di[15:8], the second SHALL return di[7:0].
REQ-016 A phase bit SHALL toggle on each accepted read; the read word pointer SHALL advance only on the low-byte read.
REQ-017 Read latency: do SHALL present the selected byte on the clk edge after read acceptance and SHALL hold it until the next accepted read.
REQ-018 A word slot SHALL be freed only when its low byte is read; full_flag SHALL deassert in the cycle after that read.
REQ-019 Occupancy: a word counter (width clog2(DEPTH)+1) SHALL count up on write only, down on low-byte read only, and hold on both or neither.
REQ-020 empty_flag SHALL be 1 when the word count is 0; a word written while empty SHALL be readable from the next cycle (empty_flag falls one cycle after the write edge).
REQ-021 Pointers SHALL wrap modulo DEPTH without a bubble.
REQ-022 Simultaneous accepted write and read SHALL both take effect in the same cycle, including when count=0 with a pending write (no bypass: the read is ignored because empty_flag=1).

Reset
REQ-023 While rst_n=0 at a clk edge: pointers=0, count=0, phase=high, do=8'h00, empty_flag=1, full_flag=0.
REQ-024 Reset mid-word SHALL discard the pending low byte and all stored data.

Configuration
REQ-025 With W2B_ALMOST_FLAGS_EN defined: the block SHALL add outputs almost_full_flag (1 when word count >= AF) and almost_empty_flag (1 when remaining bytes <= AE, where remaining bytes = 2*count minus 1 if phase=low); both reset to 0/1 respectively and update the same cycle as the count.
REQ-026 Without W2B_ALMOST_FLAGS_EN: those ports, AF/AE use and the byte-count logic SHALL be absent.

Structure
REQ-027 Package w2b_pkg SHALL hold WORD_W=16, BYTE_W=8, the default DEPTH and the phase enum (PH_HIGH, PH_LOW).
REQ-028 Storage SHALL be a sub-module w2b_ram (simple dual-port, synchronous write, 16-bit, DEPTH entries); control, flags and byte mux SHALL be in the top.

Verification
REQ-029 Reset, write 16'hA55A, read twice -> do=8'hA5, then 8'h5A; empty_flag=1 after the second read.
REQ-030 Write DEPTH words -> full_flag=1; extra write of 16'hFFFF is ignored; read 2*DEPTH bytes -> values match in high-then-low order with no FFFF.
REQ-031 Full; read one high byte with we=1 -> full_flag stays 1 and the write is dropped; read the low byte -> full_flag=0 the next cycle.
REQ-032 Continuous we at 1 word/2 cycles with continuous re -> no underflow or overflow over 3*DEPTH words; pointers wrap and the byte stream matches.
REQ-033 Write 16'h1234, read one byte (12), assert rst_n=0 for one cycle -> empty_flag=1, do=8'h00; the next write of 16'hBEEF reads back BE, EF.
REQ-034 With W2B_ALMOST_FLAGS_EN, DEPTH=16, AF=14, AE=2: after 14 writes almost_full_flag=1; draining to 2 bytes sets almost_empty_flag=1.

Source files
------------

// File: rtl/w2b_pkg.sv
// Shared constants and types for the word-to-byte FIFO.
//   WORD_W        : width of a written word
//   BYTE_W        : width of a read byte
//   DEFAULT_DEPTH : default word capacity
//   phase_e       : which half of the head word the next read returns
package w2b_pkg;

  localparam int unsigned WORD_W        = 16;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned DEFAULT_DEPTH = 16;

  typedef enum logic {
    PH_HIGH = 1'b0,
    PH_LOW  = 1'b1
  } phase_e;

endpackage

// File: rtl/w2b_ram.sv
// Word storage: simple dual-port RAM, synchronous write, combinational read.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write word
//   raddr_i : read address
//   rdata_c : word at raddr_i (combinational)
module w2b_ram
  import w2b_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WORD_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WORD_W-1:0]        rdata_c
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Contents are not reset; validity is tracked by the controller's pointers.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/word_to_byte_fifo.sv
// FIFO that accepts 16-bit words and returns them as bytes, high byte first.
// Optional feature macro: W2B_ALMOST_FLAGS_EN adds almost_full_flag_o and
// almost_empty_flag_o (thresholds AF in words, AE in bytes).
//   clk                 : clock
//   rst_n               : synchronous active-low reset
//   di_i                : write word
//   we_i                : write enable (ignored while full)
//   re_i                : read enable, one byte per accepted read (ignored while empty)
//   do_o                : last byte read, held until the next accepted read
//   empty_flag_o        : no unread bytes stored
//   full_flag_o         : DEPTH words occupied
//   almost_full_flag_o  : word count >= AF           (W2B_ALMOST_FLAGS_EN only)
//   almost_empty_flag_o : remaining bytes <= AE      (W2B_ALMOST_FLAGS_EN only)
module word_to_byte_fifo
  import w2b_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AF    = DEPTH - 2,
  parameter int unsigned AE    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] di_i,
  input  logic              we_i,
  input  logic              re_i,
  output logic [BYTE_W-1:0] do_o,
  output logic              empty_flag_o,
`ifdef W2B_ALMOST_FLAGS_EN
  output logic              almost_full_flag_o,
  output logic              almost_empty_flag_o,
`endif
  output logic              full_flag_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Reject unsupported configurations at elaboration.
  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4 || DEPTH > 1024 ||
      AF > DEPTH || AE > 2 * DEPTH) begin : g_bad_params
    $error("word_to_byte_fifo: unsupported DEPTH/AF/AE");
  end

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  phase_e            phase_q, phase_d;
  logic [BYTE_W-1:0] do_q, do_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic [WORD_W-1:0] rdata_c;
  logic              wr_ok_c, rd_ok_c, rd_low_c;

  // Acceptance uses the registered flags, so a full write stays dropped even
  // when the same cycle frees a slot.
  assign wr_ok_c  = we_i & ~full_q;
  assign rd_ok_c  = re_i & ~empty_q;
  assign rd_low_c = rd_ok_c & (phase_q == PH_LOW);

  w2b_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_ok_c),
    .waddr_i (wptr_q),
    .wdata_i (di_i),
    .raddr_i (rptr_q),
    .rdata_c (rdata_c)
  );

  // Next-state: pointers, phase, occupancy, output byte and flags.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    phase_d = phase_q;
    do_d    = do_q;

    if (wr_ok_c) begin
      wptr_d = wptr_q + PTR_W'(1);
    end

    if (rd_ok_c) begin
      do_d    = (phase_q == PH_HIGH) ? rdata_c[WORD_W-1:BYTE_W] : rdata_c[BYTE_W-1:0];
      phase_d = (phase_q == PH_HIGH) ? PH_LOW : PH_HIGH;
    end

    // Slot is released only once its low byte has been consumed.
    if (rd_low_c) begin
      rptr_d = rptr_q + PTR_W'(1);
    end

    unique case ({wr_ok_c, rd_low_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    empty_d = (count_d == CNT_W'(0));
    full_d  = (count_d == CNT_W'(DEPTH));
  end

`ifdef W2B_ALMOST_FLAGS_EN
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic [CNT_W:0]    bytes_c;

  // Bytes left: two per stored word, minus the high byte already taken.
  always_comb begin
    bytes_c  = {count_d, 1'b0} - (CNT_W + 1)'(phase_d == PH_LOW);
    afull_d  = (count_d >= CNT_W'(AF));
    aempty_d = (bytes_c <= (CNT_W + 1)'(AE));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  assign almost_full_flag_o  = afull_q;
  assign almost_empty_flag_o = aempty_q;
`endif

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      phase_q <= PH_HIGH;
      do_q    <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      phase_q <= phase_d;
      do_q    <= do_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  assign do_o         = do_q;
  assign empty_flag_o = empty_q;
  assign full_flag_o  = full_q;

endmodule

// File: tb/tb_word_to_byte_fifo.sv
// Self-checking bench for word_to_byte_fifo: directed scenarios plus random
// traffic, compared against a word-queue reference model.
module tb_word_to_byte_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] di_i = '0;
  logic        we_i = 1'b0;
  logic        re_i = 1'b0;
  logic [7:0]  do_o;
  logic        empty_flag_o;
  logic        full_flag_o;
`ifdef W2B_ALMOST_FLAGS_EN
  logic        almost_full_flag_o;
  logic        almost_empty_flag_o;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: stored words in order, and whether the head word's
  // high byte has already been consumed.
  logic [15:0] wq[$];
  bit          half = 1'b0;
  logic [7:0]  exp_do = 8'h00;

  word_to_byte_fifo #(
    .DEPTH (DEPTH),
    .AF    (AF),
    .AE    (AE)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .di_i                (di_i),
    .we_i                (we_i),
    .re_i                (re_i),
    .do_o                (do_o),
    .empty_flag_o        (empty_flag_o),
`ifdef W2B_ALMOST_FLAGS_EN
    .almost_full_flag_o  (almost_full_flag_o),
    .almost_empty_flag_o (almost_empty_flag_o),
`endif
    .full_flag_o         (full_flag_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":do"},    16'(do_o), 16'(exp_do));
    chk({tag, ":empty"}, 16'(empty_flag_o), 16'(wq.size() == 0));
    chk({tag, ":full"},  16'(full_flag_o), 16'(wq.size() == DEPTH));
`ifdef W2B_ALMOST_FLAGS_EN
    chk({tag, ":afull"},  16'(almost_full_flag_o), 16'(wq.size() >= AF));
    chk({tag, ":aempty"}, 16'(almost_empty_flag_o),
        16'((2 * wq.size() - int'(half)) <= AE));
`endif
  endtask

  // One clock with the given inputs; model updated, outputs checked after the edge.
  task automatic step(input bit w, input logic [15:0] d, input bit r, input string tag);
    bit wacc, racc;
    wacc = w && (wq.size() < DEPTH);
    racc = r && (wq.size() != 0);
    we_i = w;
    di_i = d;
    re_i = r;
    if (racc) begin
      exp_do = half ? wq[0][7:0] : wq[0][15:8];
      if (half) void'(wq.pop_front());
      half = !half;
    end
    if (wacc) wq.push_back(d);
    @(posedge clk);
    @(negedge clk);
    we_i = 1'b0;
    re_i = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input int n, input string tag);
    rst_n = 1'b0;
    we_i  = 1'b1;
    re_i  = 1'b1;
    di_i  = 16'hDEAD;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    we_i  = 1'b0;
    re_i  = 1'b0;
    wq.delete();
    half   = 1'b0;
    exp_do = 8'h00;
    check_state(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2 * DEPTH + 2 && wq.size() != 0; i++) step(1'b0, 16'h0, 1'b1, tag);
  endtask

  initial begin
    // Reset state
    do_reset(2, "reset");

    // Single word, two reads
    step(1'b1, 16'hA55A, 1'b0, "w_a55a");
    step(1'b0, 16'h0, 1'b1, "rd_hi");
    chk("a55a_hi", 16'(do_o), 16'h00A5);
    step(1'b0, 16'h0, 1'b1, "rd_lo");
    chk("a55a_lo", 16'(do_o), 16'h005A);
    chk("a55a_empty", 16'(empty_flag_o), 16'h1);
    step(1'b0, 16'h0, 1'b1, "rd_empty_hold");

    // Fill to full, extra write dropped, drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'($urandom), 1'b0, "fill");
    chk("fill_full", 16'(full_flag_o), 16'h1);
    step(1'b1, 16'hFFFF, 1'b0, "w_when_full");
    for (int i = 0; i < 2 * DEPTH; i++) step(1'b0, 16'h0, 1'b1, "drain_full");
    chk("drained_empty", 16'(empty_flag_o), 16'h1);

    // Full: high-byte read with write keeps full, low-byte read frees slot
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'($urandom), 1'b0, "fill2");
    step(1'b1, 16'h7777, 1'b1, "full_rd_hi_we");
    chk("full_stays", 16'(full_flag_o), 16'h1);
    step(1'b0, 16'h0, 1'b1, "full_rd_lo");
    chk("full_clears", 16'(full_flag_o), 16'h0);
    drain("drain2");

    // Streaming: one word every two cycles, read every cycle, pointers wrap
    for (int i = 0; i < 2 * 3 * DEPTH; i++) step(i % 2 == 0, 16'($urandom), 1'b1, "stream");
    drain("stream_tail");

    // Reset mid-word discards the pending low byte
    step(1'b1, 16'h1234, 1'b0, "w_1234");
    step(1'b0, 16'h0, 1'b1, "rd_12");
    chk("rd_12_val", 16'(do_o), 16'h0012);
    do_reset(1, "mid_reset");
    chk("mid_reset_do", 16'(do_o), 16'h0000);
    step(1'b1, 16'hBEEF, 1'b0, "w_beef");
    step(1'b0, 16'h0, 1'b1, "rd_be");
    chk("beef_hi", 16'(do_o), 16'h00BE);
    step(1'b0, 16'h0, 1'b1, "rd_ef");
    chk("beef_lo", 16'(do_o), 16'h00EF);

`ifdef W2B_ALMOST_FLAGS_EN
    // Almost thresholds
    for (int i = 0; i < AF - 1; i++) step(1'b1, 16'($urandom), 1'b0, "af_fill");
    chk("af_below", 16'(almost_full_flag_o), 16'h0);
    step(1'b1, 16'($urandom), 1'b0, "af_fill_last");
    chk("af_at", 16'(almost_full_flag_o), 16'h1);
    while (2 * wq.size() - int'(half) > AE + 1) step(1'b0, 16'h0, 1'b1, "ae_drain");
    chk("ae_above", 16'(almost_empty_flag_o), 16'h0);
    step(1'b0, 16'h0, 1'b1, "ae_drain_last");
    chk("ae_at", 16'(almost_empty_flag_o), 16'h1);
    drain("ae_tail");
`endif

    // Random traffic with varying bias
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = (i < 200) ? 70 : 30;
      step($urandom_range(99) < wp, 16'($urandom), $urandom_range(99) < 55, "rand");
    end
    drain("rand_tail");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
